dualport_ram_arbiter: RTL and testbench

Two-requester scheduler in front of the 16x8 dual-port RAM. Write traffic goes to port 0 and read traffic goes to port 1, with independent round-robin arbitration per port, so a write and a read can issue in the same cycle. Same-cycle read/write address collisions are resolved by stalling the read. Read data returns to the issuing requester with a tagged valid pulse.

---
 rtl/dualport_ram_arb_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 31 +++
 rtl/dualport_ram_arbiter.sv | 107 ++++++++++
 tb/tb_dualport_ram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dualport_ram_arb_pkg.sv
// Shared definitions for the dual-port RAM arbiter: requester ids and the
// read-return tag carried alongside the RAM read pipeline.
package dualport_ram_arb_pkg;

    localparam int unsigned REQ_0   = 0;
    localparam int unsigned REQ_1   = 1;
    localparam int unsigned NUM_REQ = 2;

    typedef struct packed {
        logic valid;
        logic id;
    } ret_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Grant is combinational; the pointer advances only when the grant is accepted.
module rr_arbiter2
    import dualport_ram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt
);

    logic last;

    // Single candidate wins outright; on contention the one not granted last wins.
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= gnt[REQ_1];
        end
    end

endmodule

// File: rtl/dualport_ram_arbiter.sv
// Two-requester scheduler for a 16x8 dual-port RAM: writes on port 0, reads on
// port 1, independent round-robin per port, reads stalled on same-cycle address collision.
module dualport_ram_arbiter
    import dualport_ram_arb_pkg::*;
#(
    parameter int unsigned addr_width = 4,
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  we_0,
    input  logic                  we_1,
    input  logic [addr_width-1:0] addr_0,
    input  logic [addr_width-1:0] addr_1,
    input  logic [data_width-1:0] wdata_0,
    input  logic [data_width-1:0] wdata_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic [data_width-1:0] rdata,
    output logic                  wr_en,
    output logic                  port_en_0,
    output logic [data_width-1:0] data_in,
    output logic [addr_width-1:0] addr_in_0,
    output logic                  port_en_1,
    output logic [addr_width-1:0] addr_in_1,
    input  logic [data_width-1:0] data_out_1
);

    logic [NUM_REQ-1:0]    wr_cand, rd_cand;
    logic [NUM_REQ-1:0]    wr_gnt_raw, rd_gnt_raw;
    logic [NUM_REQ-1:0]    wr_gnt, rd_gnt;
    logic                  wr_accept, rd_accept, collide;
    logic [addr_width-1:0] wr_addr, rd_addr;
    logic [data_width-1:0] wr_data;
    logic                  rd_id_q;
    ret_tag_t              ret_q;

    assign wr_cand = {req_1 & we_1, req_0 & we_0};
    assign rd_cand = {req_1 & ~we_1, req_0 & ~we_0};

    rr_arbiter2 u_wr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (wr_cand),
        .accept (wr_accept),
        .gnt    (wr_gnt_raw)
    );

    rr_arbiter2 u_rd_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rd_cand),
        .accept (rd_accept),
        .gnt    (rd_gnt_raw)
    );

    // A read hitting the address being written this cycle is held off one cycle.
    always_comb begin
        wr_gnt  = rst_n ? wr_gnt_raw : '0;
        wr_addr = wr_gnt[REQ_1] ? addr_1 : addr_0;
        wr_data = wr_gnt[REQ_1] ? wdata_1 : wdata_0;
        rd_addr = rd_gnt_raw[REQ_1] ? addr_1 : addr_0;
        collide = (|wr_gnt) && (|rd_gnt_raw) && (rd_addr == wr_addr);
        rd_gnt  = (rst_n && !collide) ? rd_gnt_raw : '0;
    end

    assign wr_accept = |wr_gnt;
    assign rd_accept = |rd_gnt;
    assign gnt_0     = wr_gnt[REQ_0] | rd_gnt[REQ_0];
    assign gnt_1     = wr_gnt[REQ_1] | rd_gnt[REQ_1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            port_en_0 <= 1'b0;
            addr_in_0 <= '0;
            data_in   <= '0;
            port_en_1 <= 1'b0;
            addr_in_1 <= '0;
            rd_id_q   <= 1'b0;
            ret_q     <= '0;
        end else begin
            wr_en     <= wr_accept;
            port_en_0 <= wr_accept;
            if (wr_accept) begin
                addr_in_0 <= wr_addr;
                data_in   <= wr_data;
            end
            port_en_1 <= rd_accept;
            if (rd_accept) begin
                addr_in_1 <= rd_addr;
                rd_id_q   <= rd_gnt[REQ_1];
            end
            // Tag lines up with the cycle the RAM presents the registered read data.
            ret_q <= '{valid: port_en_1, id: rd_id_q};
        end
    end

    assign rvalid_0 = ret_q.valid & ~ret_q.id;
    assign rvalid_1 = ret_q.valid & ret_q.id;
    assign rdata    = data_out_1;

endmodule

// File: tb/tb_dualport_ram_arbiter.sv
// Directed bench for dualport_ram_arbiter with a behavioural 16x8 RAM
// (registered read on port 1) attached to the RAM-side ports.
module tb_dualport_ram_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_0, req_1, we_0, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [DW-1:0] rdata;
    logic          wr_en, port_en_0, port_en_1;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr_in_0, addr_in_1;
    logic [DW-1:0] data_out_1;

    int checks = 0;
    int errors = 0;

    dualport_ram_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_0      (req_0),
        .req_1      (req_1),
        .we_0       (we_0),
        .we_1       (we_1),
        .addr_0     (addr_0),
        .addr_1     (addr_1),
        .wdata_0    (wdata_0),
        .wdata_1    (wdata_1),
        .gnt_0      (gnt_0),
        .gnt_1      (gnt_1),
        .rvalid_0   (rvalid_0),
        .rvalid_1   (rvalid_1),
        .rdata      (rdata),
        .wr_en      (wr_en),
        .port_en_0  (port_en_0),
        .data_in    (data_in),
        .addr_in_0  (addr_in_0),
        .port_en_1  (port_en_1),
        .addr_in_1  (addr_in_1),
        .data_out_1 (data_out_1)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:15];
    always @(posedge clk) begin
        if (port_en_0 && wr_en) mem[addr_in_0] <= data_in;
        if (port_en_1) data_out_1 <= mem[addr_in_1];
    end

    task automatic drive(input int n, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d;
        end else begin
            req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d;
        end
    endtask

    task automatic idle();
        req_0 = 1'b0;
        req_1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 4'd3, 8'hA5);
        drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt_0, gnt_1, rvalid_0, rvalid_1, wr_en, port_en_0, port_en_1,
             addr_in_0, addr_in_1, data_in} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b%b rv=%b%b we=%b pe=%b%b a0=%h a1=%h d=%h exp all 0",
                     gnt_0, gnt_1, rvalid_0, rvalid_1, wr_en, port_en_0, port_en_1,
                     addr_in_0, addr_in_1, data_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt_0 !== 1'b1) begin
            errors++;
            $display("FAIL first_write_gnt got %b exp 1", gnt_0);
        end
        @(negedge clk);
        idle();
        checks++;
        if ({wr_en, port_en_0, addr_in_0, data_in, port_en_1} !== {1'b1, 1'b1, 4'd3, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL first_write_drive got we=%b pe0=%b a=%h d=%h pe1=%b exp 1 1 3 a5 0",
                     wr_en, port_en_0, addr_in_0, data_in, port_en_1);
        end
        @(negedge clk);
        checks++;
        if ({wr_en, port_en_0, addr_in_0, data_in} !== {1'b0, 1'b0, 4'd3, 8'hA5}) begin
            errors++;
            $display("FAIL write_hold got we=%b pe0=%b a=%h d=%h exp 0 0 3 a5",
                     wr_en, port_en_0, addr_in_0, data_in);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        checks++;
        if (gnt_0 !== 1'b1) begin
            errors++;
            $display("FAIL midread_gnt got %b exp 1", gnt_0);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt_0, port_en_1, wr_en, port_en_0, addr_in_0, addr_in_1, data_in,
             rvalid_0, rvalid_1} !== '0) begin
            errors++;
            $display("FAIL midread_async got g0=%b pe1=%b we=%b pe0=%b a0=%h a1=%h d=%h rv=%b%b exp all 0",
                     gnt_0, port_en_1, wr_en, port_en_0, addr_in_0, addr_in_1, data_in,
                     rvalid_0, rvalid_1);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rvalid_0, rvalid_1} !== 2'b00) begin
                errors++;
                $display("FAIL midread_dropped cycle %0d got rv=%b%b exp 00", i, rvalid_0, rvalid_1);
            end
        end
        drive(0, 1'b1, 1'b0, 4'd8, 8'h00);
        drive(1, 1'b1, 1'b0, 4'd9, 8'h00);
        #1;
        checks++;
        if ({gnt_0, gnt_1} !== 2'b10) begin
            errors++;
            $display("FAIL midread_priority got g0g1=%b%b exp 10", gnt_0, gnt_1);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++;
        if ({rvalid_0, rvalid_1} !== 2'b10) begin
            errors++;
            $display("FAIL midread_return got rv=%b%b exp 10", rvalid_0, rvalid_1);
        end
        @(negedge clk);
    endtask

    task automatic test_write_contention();
        logic          exp_g0;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'd1, 8'h11);
        drive(1, 1'b1, 1'b1, 4'd2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_g0 = (i % 2 == 0);
            checks++;
            if ({gnt_0, gnt_1} !== {exp_g0, ~exp_g0}) begin
                errors++;
                $display("FAIL contention_gnt %0d got g0g1=%b%b exp %b%b", i, gnt_0, gnt_1, exp_g0, ~exp_g0);
            end
            if (i > 0) begin
                exp_a = (i % 2 == 1) ? 4'd1 : 4'd2;
                exp_d = (i % 2 == 1) ? 8'h11 : 8'h22;
                checks++;
                if ({wr_en, addr_in_0, data_in} !== {1'b1, exp_a, exp_d}) begin
                    errors++;
                    $display("FAIL contention_ram %0d got we=%b a=%h d=%h exp 1 %h %h",
                             i, wr_en, addr_in_0, data_in, exp_a, exp_d);
                end
            end
        end
        @(negedge clk);
        idle();
        checks++;
        if ({wr_en, addr_in_0, data_in} !== {1'b1, 4'd2, 8'h22}) begin
            errors++;
            $display("FAIL contention_last got we=%b a=%h d=%h exp 1 2 22", wr_en, addr_in_0, data_in);
        end
    endtask

    task automatic test_parallel_ports();
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 4'd4, 8'h44);
        #1;
        checks++;
        if ({gnt_0, gnt_1} !== 2'b01) begin
            errors++;
            $display("FAIL parallel_prewrite got g0g1=%b%b exp 01", gnt_0, gnt_1);
        end
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'd5, 8'h55);
        drive(1, 1'b1, 1'b0, 4'd4, 8'h00);
        #1;
        checks++;
        if ({gnt_0, gnt_1} !== 2'b11) begin
            errors++;
            $display("FAIL parallel_gnt got g0g1=%b%b exp 11", gnt_0, gnt_1);
        end
        @(negedge clk);
        idle();
        checks++;
        if ({port_en_0, wr_en, addr_in_0, data_in, port_en_1, addr_in_1, rvalid_1} !==
            {1'b1, 1'b1, 4'd5, 8'h55, 1'b1, 4'd4, 1'b0}) begin
            errors++;
            $display("FAIL parallel_ram got pe0=%b we=%b a0=%h d=%h pe1=%b a1=%h rv1=%b exp 1 1 5 55 1 4 0",
                     port_en_0, wr_en, addr_in_0, data_in, port_en_1, addr_in_1, rvalid_1);
        end
        @(negedge clk);
        checks++;
        if ({rvalid_0, rvalid_1, rdata} !== {1'b0, 1'b1, 8'h44}) begin
            errors++;
            $display("FAIL parallel_read got rv=%b%b rdata=%h exp 01 44", rvalid_0, rvalid_1, rdata);
        end
        @(negedge clk);
        checks++;
        if ({rvalid_0, rvalid_1} !== 2'b00) begin
            errors++;
            $display("FAIL parallel_single_pulse got rv=%b%b exp 00", rvalid_0, rvalid_1);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'd7, 8'h77);
        drive(1, 1'b1, 1'b0, 4'd7, 8'h00);
        #1;
        checks++;
        if ({gnt_0, gnt_1} !== 2'b10) begin
            errors++;
            $display("FAIL collision_stall got g0g1=%b%b exp 10", gnt_0, gnt_1);
        end
        @(negedge clk);
        req_0 = 1'b0;
        #1;
        checks++;
        if ({gnt_1, port_en_1, wr_en, addr_in_0, data_in} !== {1'b1, 1'b0, 1'b1, 4'd7, 8'h77}) begin
            errors++;
            $display("FAIL collision_retry got g1=%b pe1=%b we=%b a0=%h d=%h exp 1 0 1 7 77",
                     gnt_1, port_en_1, wr_en, addr_in_0, data_in);
        end
        @(negedge clk);
        idle();
        checks++;
        if ({port_en_1, addr_in_1, rvalid_1} !== {1'b1, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL collision_rd_drive got pe1=%b a1=%h rv1=%b exp 1 7 0", port_en_1, addr_in_1, rvalid_1);
        end
        @(negedge clk);
        checks++;
        if ({rvalid_1, rdata} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL collision_read got rv1=%b rdata=%h exp 1 77", rvalid_1, rdata);
        end
    endtask

    task automatic test_fill_readback();
        int   rv_count;
        logic exp_v;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 1'b1, 4'(i), 8'(i + 1));
            #1;
            checks++;
            if (gnt_0 !== 1'b1) begin
                errors++;
                $display("FAIL fill_gnt addr %0d got %b exp 1", i, gnt_0);
            end
        end
        rv_count = 0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            req_0 = 1'b0;
            if (k < 16) drive(1, 1'b1, 1'b0, 4'(k), 8'h00);
            else req_1 = 1'b0;
            #1;
            if (k < 16) begin
                checks++;
                if (gnt_1 !== 1'b1) begin
                    errors++;
                    $display("FAIL readback_gnt addr %0d got %b exp 1", k, gnt_1);
                end
            end
            exp_v = (k >= 2 && k <= 17);
            checks++;
            if (rvalid_1 !== exp_v) begin
                errors++;
                $display("FAIL readback_valid cycle %0d got %b exp %b", k, rvalid_1, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (rdata !== 8'(k - 1)) begin
                    errors++;
                    $display("FAIL readback_data cycle %0d got %h exp %h", k, rdata, 8'(k - 1));
                end
            end
            if (rvalid_1 === 1'b1) rv_count++;
        end
        checks++;
        if (rv_count != 16) begin
            errors++;
            $display("FAIL readback_count got %0d exp 16", rv_count);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_read();
        test_write_contention();
        test_parallel_ports();
        test_collision();
        test_fill_readback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1);
    end

endmodule
